// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronizes and debounces porb/ext_resetb, then releases
// the core reset followed by the user-area reset, with soft user reset and sticky cause flags.
module por_reset_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd4,
   parameter int unsigned CORE_DELAY      = 32'd8,
   parameter int unsigned USER_DELAY      = 32'd16,
   parameter int unsigned CNT_W           = 32'd16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       porb,
   input  logic       ext_resetb,
   input  logic       soft_rst_req,
   input  logic       cause_clr,
   output logic       rstn_core,
   output logic       rstn_user,
   output logic       seq_done,
   output logic [2:0] state,
   output logic       cause_por,
   output logic       cause_ext
);

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_DEBOUNCE  = 3'd1,
      ST_CORE_WAIT = 3'd2,
      ST_USER_WAIT = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 32'd1);
   localparam logic [CNT_W-1:0] USER_LAST = CNT_W'(USER_DELAY - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

   logic [1:0]       porb_sync_q, porb_sync_d;
   logic [1:0]       ext_sync_q,  ext_sync_d;
   state_t           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             rstn_core_q, rstn_core_d;
   logic             rstn_user_q, rstn_user_d;
   logic             seq_done_q,  seq_done_d;
   logic             cause_por_q, cause_por_d;
   logic             cause_ext_q, cause_ext_d;
   logic             porb_s, ext_s, in_ok;

   assign porb_s = porb_sync_q[1];
   assign ext_s  = ext_sync_q[1];
   assign in_ok  = porb_s & ext_s;

   always_comb begin
      porb_sync_d = {porb_sync_q[0], porb};
      ext_sync_d  = {ext_sync_q[0], ext_resetb};

      // a set condition in the same cycle beats the clear
      if (!porb_s) begin
         cause_por_d = 1'b1;
      end else if (cause_clr) begin
         cause_por_d = 1'b0;
      end else begin
         cause_por_d = cause_por_q;
      end

      if (!ext_s) begin
         cause_ext_d = 1'b1;
      end else if (cause_clr) begin
         cause_ext_d = 1'b0;
      end else begin
         cause_ext_d = cause_ext_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rstn_core_d = rstn_core_q;
      rstn_user_d = rstn_user_q;
      seq_done_d  = seq_done_q;

      if (!in_ok && (state_q != ST_RESET)) begin
         state_d     = ST_RESET;
         cnt_d       = CNT_ZERO;
         rstn_core_d = 1'b0;
         rstn_user_d = 1'b0;
         seq_done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_RESET: begin
               cnt_d       = CNT_ZERO;
               rstn_core_d = 1'b0;
               rstn_user_d = 1'b0;
               seq_done_d  = 1'b0;
               if (in_ok) begin
                  state_d = ST_DEBOUNCE;
               end else begin
                  state_d = ST_RESET;
               end
            end
            ST_DEBOUNCE: begin
               if (cnt_q == DEB_LAST) begin
                  state_d = ST_CORE_WAIT;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_CORE_WAIT: begin
               if (cnt_q == CORE_LAST) begin
                  state_d     = ST_USER_WAIT;
                  cnt_d       = CNT_ZERO;
                  rstn_core_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_USER_WAIT: begin
               if (cnt_q == USER_LAST) begin
                  state_d     = ST_RUN;
                  cnt_d       = CNT_ZERO;
                  rstn_user_d = 1'b1;
                  seq_done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_RUN: begin
               // soft request re-runs only the user stage; core stays released
               if (soft_rst_req) begin
                  state_d     = ST_USER_WAIT;
                  cnt_d       = CNT_ZERO;
                  rstn_user_d = 1'b0;
                  seq_done_d  = 1'b0;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d     = ST_RESET;
               cnt_d       = CNT_ZERO;
               rstn_core_d = 1'b0;
               rstn_user_d = 1'b0;
               seq_done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         porb_sync_q <= 2'b00;
         ext_sync_q  <= 2'b00;
         state_q     <= ST_RESET;
         cnt_q       <= CNT_ZERO;
         rstn_core_q <= 1'b0;
         rstn_user_q <= 1'b0;
         seq_done_q  <= 1'b0;
         cause_por_q <= 1'b1;
         cause_ext_q <= 1'b0;
      end else begin
         porb_sync_q <= porb_sync_d;
         ext_sync_q  <= ext_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rstn_core_q <= rstn_core_d;
         rstn_user_q <= rstn_user_d;
         seq_done_q  <= seq_done_d;
         cause_por_q <= cause_por_d;
         cause_ext_q <= cause_ext_d;
      end
   end

   assign rstn_core = rstn_core_q;
   assign rstn_user = rstn_user_q;
   assign seq_done  = seq_done_q;
   assign state     = state_q;
   assign cause_por = cause_por_q;
   assign cause_ext = cause_ext_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Bench for por_reset_sequencer: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a timestamp-based reference model.
module tb_por_reset_sequencer;

   localparam int D = 4;
   localparam int C = 8;
   localparam int U = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       porb = 1'b0;
   logic       ext_resetb = 1'b1;
   logic       soft_rst_req = 1'b0;
   logic       cause_clr = 1'b0;
   logic       rstn_core, rstn_user, seq_done, cause_por, cause_ext;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   por_reset_sequencer #(
      .DEBOUNCE_CYCLES(D), .CORE_DELAY(C), .USER_DELAY(U), .CNT_W(16)
   ) dut (
      .clk(clk), .resetn(resetn), .porb(porb), .ext_resetb(ext_resetb),
      .soft_rst_req(soft_rst_req), .cause_clr(cause_clr),
      .rstn_core(rstn_core), .rstn_user(rstn_user), .seq_done(seq_done),
      .state(state), .cause_por(cause_por), .cause_ext(cause_ext)
   );

   always #5 clk = ~clk;

   // Reference model: releases are derived from the edge at which in_ok became
   // continuously high (qual) and the edge the user countdown started (user_ref).
   int         n = 0;
   int         qual = 0;
   int         user_ref = 0;
   int         m_el;
   bit         qual_v = 1'b0;
   bit         ps1 = 1'b0, ps2 = 1'b0, es1 = 1'b0, es2 = 1'b0;
   bit         m_ok, m_was_run;
   logic       m_core = 1'b0, m_user = 1'b0, m_done = 1'b0, m_cpor = 1'b1, m_cext = 1'b0;
   logic [2:0] m_state = 3'd0;

   always begin
      @(posedge clk);
      n = n + 1;
      if (!resetn) begin
         ps1 = 1'b0; ps2 = 1'b0; es1 = 1'b0; es2 = 1'b0;
         qual_v = 1'b0;
         m_core = 1'b0; m_user = 1'b0; m_done = 1'b0; m_state = 3'd0;
         m_cpor = 1'b1; m_cext = 1'b0;
      end else begin
         m_ok      = ps2 & es2;
         m_was_run = (m_state == 3'd4);
         if (!ps2) m_cpor = 1'b1; else if (cause_clr) m_cpor = 1'b0;
         if (!es2) m_cext = 1'b1; else if (cause_clr) m_cext = 1'b0;
         if (!m_ok) begin
            qual_v = 1'b0;
            m_core = 1'b0; m_user = 1'b0; m_done = 1'b0; m_state = 3'd0;
         end else begin
            if (!qual_v) begin
               qual_v   = 1'b1;
               qual     = n;
               user_ref = n + D + C;
            end
            if (m_was_run && soft_rst_req) user_ref = n;
            m_el   = n - qual;
            m_core = (m_el >= D + C);
            m_user = m_core && ((n - user_ref) >= U);
            m_done = m_user;
            if (m_el < D)          m_state = 3'd1;
            else if (m_el < D + C) m_state = 3'd2;
            else if (m_user)       m_state = 3'd4;
            else                   m_state = 3'd3;
         end
         ps2 = ps1; ps1 = porb;
         es2 = es1; es1 = ext_resetb;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (n > 0) begin
         check("model", {rstn_core, rstn_user, seq_done, state, cause_por, cause_ext},
               {m_core, m_user, m_done, m_state, m_cpor, m_cext});
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      step(3);
      check("reset_vals", {rstn_core, rstn_user, seq_done, state, cause_por, cause_ext},
            8'b000_000_10);

      // cold start: porb rises before edge 0
      resetn = 1'b1;
      porb   = 1'b1;
      step(3);
      check("cold_state_e2", {5'd0, state}, 8'd1);
      step(4);
      check("cold_state_e6", {5'd0, state}, 8'd2);
      step(7);
      check("cold_core_e13", {6'd0, rstn_core, m_core}, 8'd0);
      step(1);
      check("cold_core_e14", {3'd0, rstn_core, m_core, state}, 8'b000_11_011);
      step(15);
      check("cold_user_e29", {6'd0, rstn_user, m_user}, 8'd0);
      step(1);
      check("cold_user_e30", {1'b0, rstn_user, m_user, seq_done, m_done, state}, 8'b0_1111_100);

      // cause_clr in RUN
      cause_clr = 1'b1;
      step(1);
      cause_clr = 1'b0;
      check("clr_in_run", {6'd0, cause_por, cause_ext}, 8'd0);

      // soft reset in RUN; a second request during USER_WAIT is ignored
      soft_rst_req = 1'b1;
      step(1);
      soft_rst_req = 1'b0;
      check("soft_e0", {2'd0, rstn_core, rstn_user, seq_done, state}, 8'b00_100_011);
      for (int k = 1; k <= 15; k++) begin
         soft_rst_req = (k == 6);
         step(1);
         check("soft_low", {6'd0, rstn_core, rstn_user}, 8'd2);
      end
      soft_rst_req = 1'b0;
      step(1);
      check("soft_e16", {2'd0, rstn_core, rstn_user, seq_done, state}, 8'b00_111_100);

      // brown-out in RUN
      porb = 1'b0;
      step(1);
      porb = 1'b1;
      step(2);
      check("brownout", {2'd0, rstn_core, rstn_user, cause_por, state}, 8'b00_001_000);
      step(35);
      check("brownout_rerun", {4'd0, rstn_user, state}, 8'b0000_1_100);

      // cause_clr coinciding with porb_s low keeps cause_por set
      cause_clr = 1'b1;
      step(1);
      cause_clr = 1'b0;
      porb = 1'b0;
      step(1);
      porb = 1'b1;
      step(1);
      cause_clr = 1'b1;
      step(1);
      cause_clr = 1'b0;
      check("clr_vs_set", {6'd0, cause_por, m_cpor}, 8'd3);
      step(40);

      // glitch rejection from RESET
      porb = 1'b0;
      step(4);
      porb = 1'b1;
      step(3);
      porb = 1'b0;
      step(1);
      porb = 1'b1;
      step(14);
      check("glitch_core_f13", {6'd0, rstn_core, m_core}, 8'd0);
      step(1);
      check("glitch_core_f14", {6'd0, rstn_core, m_core}, 8'd3);
      step(20);

      // external reset in the middle of CORE_WAIT
      ext_resetb = 1'b0;
      step(4);
      ext_resetb = 1'b1;
      step(9);
      check("ext_in_core_wait", {5'd0, state}, 8'd2);
      ext_resetb = 1'b0;
      step(3);
      check("ext_drop", {3'd0, rstn_core, cause_ext, state}, 8'b000_01_000);
      ext_resetb = 1'b1;
      step(40);

      // randomized stimulus
      for (int i = 0; i < 3000; i++) begin
         resetn       = ($urandom_range(0, 599) != 0);
         porb         = ($urandom_range(0, 119) != 0);
         ext_resetb   = ($urandom_range(0, 149) != 0);
         soft_rst_req = ($urandom_range(0, 15) == 0);
         cause_clr    = ($urandom_range(0, 23) == 0);
         step(1);
      end
      resetn = 1'b1; porb = 1'b1; ext_resetb = 1'b1;
      soft_rst_req = 1'b0; cause_clr = 1'b0;
      step(40);
      check("final_run", {5'd0, state}, 8'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
